// File: rtl/sfx_arbiter.sv
// sfx_arbiter: fixed-priority, preemptive sequencer sharing one tone generator
// among four sound effects, each a short note list followed by a silent gap.
module sfx_arbiter #(
   parameter int NOTE_CYCLES = 12500000,
   parameter int GAP_CYCLES  = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       mute,
   output logic [2:0] sel,
   output logic       en,
   output logic       busy,
   output logic [1:0] active_id,
   output logic       done
);
   localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2;

   logic [1:0]  state, state_n, id_n, note_idx, idx_n, top_id, last_idx;
   logic [3:0]  pending, pend_n, cand, above, grant_mask, play_mask;
   logic [31:0] cnt, cnt_n;
   logic        grant, done_n, note_end, gap_end;

   function automatic logic [2:0] tone(input logic [1:0] id, input logic [1:0] idx);
      case ({id, idx})
         4'h0: tone = 3'd5;
         4'h1: tone = 3'd7;
         4'h4: tone = 3'd1;
         4'h8: tone = 3'd3;
         4'h9: tone = 3'd4;
         4'hA: tone = 3'd5;
         4'hB: tone = 3'd7;
         4'hC: tone = 3'd6;
         4'hD: tone = 3'd4;
         4'hE: tone = 3'd2;
         4'hF: tone = 3'd1;
         default: tone = 3'd0;
      endcase
   endfunction

   always_comb begin
      cand       = req | pending;
      above      = cand & ~((4'd2 << active_id) - 4'd1);
      top_id     = cand[3] ? 2'd3 : cand[2] ? 2'd2 : cand[1] ? 2'd1 : 2'd0;
      last_idx   = active_id == 2'd0 ? 2'd1 : active_id == 2'd1 ? 2'd0 : 2'd3;
      note_end   = cnt == 32'(NOTE_CYCLES - 1);
      gap_end    = cnt == 32'(GAP_CYCLES - 1);
      state_n    = state;
      id_n       = active_id;
      idx_n      = note_idx;
      cnt_n      = cnt + 32'd1;
      grant      = 1'b0;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = cnt;
            grant = |cand;
         end
         PLAY: begin
            if (|above)
               grant = 1'b1;
            else if (note_end) begin
               cnt_n = '0;
               if (note_idx == last_idx) begin
                  state_n = GAP;
                  done_n  = 1'b1;
               end else
                  idx_n = note_idx + 2'd1;
            end
         end
         GAP: begin
            if (gap_end) begin
               cnt_n   = '0;
               state_n = IDLE;
               grant   = |cand;
            end
         end
         default: state_n = IDLE;
      endcase
      if (grant) begin
         state_n = PLAY;
         id_n    = top_id;
         idx_n   = 2'd0;
         cnt_n   = '0;
      end
      // a repeat request for the effect already playing is merged, not queued
      play_mask  = state == PLAY ? 4'd1 << active_id : 4'd0;
      grant_mask = grant ? 4'd1 << top_id : 4'd0;
      pend_n     = (pending | (req & ~play_mask)) & ~grant_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pending   <= '0;
         active_id <= '0;
         note_idx  <= '0;
         cnt       <= '0;
         sel       <= '0;
         en        <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         pending   <= pend_n;
         active_id <= id_n;
         note_idx  <= idx_n;
         cnt       <= cnt_n;
         sel       <= state_n == PLAY ? tone(id_n, idx_n) : 3'd0;
         en        <= state_n == PLAY && !mute;
         busy      <= state_n != IDLE;
         done      <= done_n;
      end
   end
endmodule

// File: tb/tb_sfx_arbiter.sv
// tb_sfx_arbiter: directed plan plus random traffic, checked every cycle
// against a behavioural model of the effect arbiter.
module tb_sfx_arbiter;
   localparam int NOTE = 4, GAP = 2;

   logic       clk = 1'b0, rst = 1'b1, mute = 1'b0;
   logic [3:0] req = 4'h0;
   logic [2:0] sel;
   logic       en, busy, done;
   logic [1:0] active_id;

   int checks = 0, failures = 0;

   // model state: 0 idle, 1 playing, 2 gap
   int       m_st = 0, m_aid = 0, m_ni = 0, m_cnt = 0;
   bit [3:0] m_pend = 0;
   bit       m_done = 0;
   int       tbl_len [4] = '{2, 1, 4, 4};
   int       tbl [4][4] = '{'{5, 7, 0, 0}, '{1, 0, 0, 0}, '{3, 4, 5, 7}, '{6, 4, 2, 1}};

   sfx_arbiter #(.NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst(rst), .req(req), .mute(mute), .sel(sel), .en(en),
      .busy(busy), .active_id(active_id), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int highest(input bit [3:0] c);
      for (int i = 3; i >= 0; i--) if (c[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      bit [3:0] cand;
      int g, top, old_st, old_aid;
      if (rst) begin
         m_st = 0; m_pend = 0; m_aid = 0; m_ni = 0; m_cnt = 0; m_done = 0;
         return;
      end
      cand = req | m_pend;
      top = highest(cand);
      g = -1;
      old_st = m_st;
      old_aid = m_aid;
      m_done = 0;
      if (m_st == 0) begin
         if (cand != 0) g = top;
      end else if (m_st == 1) begin
         if (top > m_aid) g = top;
         else if (m_cnt == NOTE - 1) begin
            m_cnt = 0;
            if (m_ni == tbl_len[m_aid] - 1) begin m_st = 2; m_done = 1; end
            else m_ni++;
         end else m_cnt++;
      end else begin
         if (m_cnt == GAP - 1) begin
            m_cnt = 0; m_st = 0;
            if (cand != 0) g = top;
         end else m_cnt++;
      end
      if (g >= 0) begin m_st = 1; m_aid = g; m_ni = 0; m_cnt = 0; end
      for (int i = 0; i < 4; i++) begin
         if (req[i] && !(old_st == 1 && old_aid == i)) m_pend[i] = 1'b1;
         if (g == i) m_pend[i] = 1'b0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      chk("sel", 32'(sel), m_st == 1 ? 32'(tbl[m_aid][m_ni]) : 32'd0);
      chk("en", 32'(en), 32'(m_st == 1 && !mute));
      chk("busy", 32'(busy), 32'(m_st != 0));
      chk("active_id", 32'(active_id), 32'(m_aid));
      chk("done", 32'(done), 32'(m_done));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      int s2 [12] = '{5, 5, 5, 5, 7, 7, 7, 7, 0, 0, 0, 0};
      int dones, done_at;
      // 1: reset with all requests held
      rst = 1; req = 4'hF;
      run(3);
      chk("rst_outputs", {29'd0, sel}, 32'd0);
      rst = 0; req = 4'h0;
      run(6);
      chk("post_rst_idle", 32'(busy), 32'd0);
      // 2: single scroll pickup
      req = 4'h1;
      cyc();
      req = 4'h0;
      chk("s2_first", 32'(sel), 32'd5);
      for (int k = 1; k < 12; k++) begin
         cyc();
         chk("s2_sel", 32'(sel), 32'(s2[k]));
         chk("s2_done", 32'(done), 32'(k == 8));
         if (k >= 10) chk("s2_busy", 32'(busy), 32'd0);
      end
      // 3: simultaneous level pass and wall bump
      req = 4'h6;
      cyc();
      req = 4'h0;
      chk("s3_id", 32'(active_id), 32'd2);
      dones = 0;
      for (int k = 1; k < 30; k++) begin
         cyc();
         if (k == 18) chk("s3_second", 32'(active_id), 32'd1);
         if (done) dones++;
      end
      chk("s3_dones", 32'(dones), 32'd2);
      // 4: death preempts scroll pickup
      req = 4'h1; cyc();
      req = 4'h0; cyc();
      chk("s4_pre", 32'(sel), 32'd5);
      req = 4'h8; cyc();
      req = 4'h0;
      chk("s4_sel", 32'(sel), 32'd6);
      chk("s4_id", 32'(active_id), 32'd3);
      dones = 0;
      for (int k = 0; k < 25; k++) begin
         cyc();
         if (done) dones++;
         if (k == 14) chk("s4_done_time", 32'(done), 32'd0);
      end
      chk("s4_dones", 32'(dones), 32'd1);
      // 5: muted level pass
      mute = 1; req = 4'h4;
      cyc();
      req = 4'h0;
      done_at = -1;
      for (int k = 1; k < 20; k++) begin
         cyc();
         chk("s5_en", 32'(en), 32'd0);
         if (done && done_at < 0) done_at = k;
      end
      chk("s5_done_at", 32'(done_at), 32'd16);
      mute = 0;
      // 6: merged duplicate, queued lower request, then reset mid-play
      req = 4'h2; cyc();
      req = 4'h0; cyc();
      req = 4'h2; cyc();
      req = 4'h1; cyc();
      req = 4'h0;
      chk("s6_pending", 32'(dut.pending), 32'h1);
      rst = 1; cyc();
      rst = 0;
      chk("s6_pending_rst", 32'(dut.pending), 32'h0);
      chk("s6_sel_rst", 32'(sel), 32'd0);
      run(10);
      chk("s6_idle", 32'(busy), 32'd0);
      // random traffic
      for (int k = 0; k < 4000; k++) begin
         rst = ($urandom % 400) == 0;
         for (int i = 0; i < 4; i++) req[i] = ($urandom % 12) == 0;
         if (($urandom % 32) == 0) mute = ~mute;
         cyc();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sfx_arbiter.md
Name: sfx_arbiter

Overview:
- Shares the single Audio tone generator between four sound-effect requesters: scroll pickup, wall bump, level pass and death.
- Sits between the game logic (Scrolls, Obstacles, FSM) and the Audio module's `sel`/`en` inputs, replacing direct keyboard-decoded tone selection.
- Arbitrates by fixed priority, with preemption.
- Sequences each effect as a fixed list of notes, each held for a programmable duration, followed by a silent gap.

Parameters:
- NOTE_CYCLES, 12500000, clk cycles each note is held (125 ms at 100 MHz); must be >= 1.
- GAP_CYCLES, 2500000, silent clk cycles after an effect completes; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req  input  4  effect requests; bit 3 = death (highest priority), 2 = level pass, 1 = wall bump, 0 = scroll pickup (lowest); any cycle high counts as a request
- mute  input  1  forces en low; sequencing and timing are unaffected
- sel  output  3  tone select to Audio; 0 = silence
- en  output  1  audio enable to Audio
- busy  output  1  high whenever state != IDLE
- active_id  output  2  effect currently playing; holds its last value otherwise
- done  output  1  one-cycle pulse when an effect completes all its notes

Behaviour:
- Reset: clk/rst as above. State IDLE, pending = 0, sel = 0, en = 0, busy = 0, active_id = 0, done = 0, counters = 0. Reset mid-operation aborts playback and discards all pending requests.
- Note table (sel values, in play order):
  - id0: 5, 7
  - id1: 1
  - id2: 3, 4, 5, 7
  - id3: 6, 4, 2, 1
- Request set: `cand = req | pending`. Selection picks the highest set bit of cand.
- pending[i] is set by req[i], except:
  - it is not set while id i is the playing effect; that request is merged and ignored;
  - it is not set in the cycle that i is granted.
- pending[i] is cleared on grant.
- IDLE:
  - sel = 0, en = 0.
  - If cand != 0: next state PLAY, active_id = selected id, note_idx = 0, cnt = 0.
  - Latency: req high at edge k gives sel = first note valid after edge k.
- PLAY:
  - sel = table[active_id][note_idx]; en = ~mute.
  - cnt increments each cycle.
  - At cnt == NOTE_CYCLES-1:
    - if this is not the last note: note_idx++, cnt = 0;
    - if it is the last note: state GAP, cnt = 0, done = 1 for exactly the first GAP cycle.
- Preemption:
  - In PLAY, if cand has any bit above active_id, switch at the next edge to the highest such id, with note_idx = 0 and cnt = 0.
  - The preempted effect is dropped: it is not resumed and gets no done pulse.
  - Lower-priority requests during PLAY go to pending.
- GAP:
  - sel = 0, en = 0; requests accumulate in pending; no preemption.
  - At cnt == GAP_CYCLES-1:
    - if cand != 0, go directly to PLAY with the highest id (no IDLE cycle);
    - otherwise go to IDLE.
- Counter width: 32 bits. Comparisons are exact equality; no wrap-around occurs for legal parameters.
- All outputs are registered.

Test Plan (NOTE_CYCLES=4, GAP_CYCLES=2):
1. Reset: hold rst 3 cycles with req=4'hF.
   -> All outputs are 0 during and after reset; nothing plays once rst and req are low.
2. Single effect: req[0] pulse at cycle 10.
   -> sel=5 on cycles 11-14, sel=7 on 15-18; en=1 on 11-18.
   -> done=1 on cycle 19; sel=0 on 19-20; busy=0 from cycle 21.
3. Simultaneous requests: req[1] and req[2] high together at cycle 10.
   -> active_id=2 with sel 3,4,5,7 on cycles 11-26; gap on 27-28.
   -> active_id=1 with sel=1 on 29-32; done on 27 and 33.
4. Preemption: req[0] at cycle 10, req[3] at cycle 12.
   -> sel=5 on 11-12; sel=6 from cycle 13 with active_id=3.
   -> The id0 effect never completes; done fires only after the id3 sequence.
5. Mute: mute=1 throughout, req[2] at cycle 10.
   -> en=0 at all times; sel sequence and done timing are identical to unmuted operation (done on cycle 27).
6. Mid-play reset and merge: req[1] at cycle 10, req[1] again at 12, req[0] at 13, rst at cycle 14.
   -> Before the reset, the duplicate req[1] leaves pending[1]=0 while req[0] sets pending[0].
   -> From cycle 15 all outputs are 0 and pending is cleared; nothing plays afterwards.
